// File: rtl/exec_stage_md.sv
// exec_stage_md: execute stage with forwarding, ALU, iterative mul/div and registered EX/MEM output
module exec_stage_md #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int MD_EN   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    flush_in,
  input  logic                    hold_in,
  input  logic [1:0]              alu_src_in,
  input  logic [3:0]              alu_op_in,
  input  logic                    md_en_in,
  input  logic [2:0]              md_op_in,
  input  logic [1:0]              branch_in,
  input  logic [1:0]              reg_in_sel_in,
  input  logic [3:0]              dwe_in,
  input  logic [2:0]              func3_in,
  input  logic                    mem_reg_in,
  input  logic                    reg_wr_in,
  input  logic [XLEN-1:0]         rv1_in,
  input  logic [XLEN-1:0]         rv2_in,
  input  logic [XLEN-1:0]         imm_in,
  input  logic [XLEN-1:0]         pc_in,
  input  logic [4:0]              rd_in,
  input  logic [NUM_FWD-1:0]      fwd_rs1_sel_in,
  input  logic [NUM_FWD-1:0]      fwd_rs2_sel_in,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data_in,
  output logic                    stall_out,
  output logic                    out_valid,
  output logic [XLEN-1:0]         alu_out,
  output logic [XLEN-1:0]         rv2_out,
  output logic [XLEN-1:0]         pc_imm_out,
  output logic [XLEN-1:0]         pc4_out,
  output logic [XLEN-1:0]         imm_out,
  output logic                    zero_out,
  output logic [4:0]              rd_out,
  output logic [1:0]              branch_out,
  output logic [1:0]              reg_in_sel_out,
  output logic [3:0]              dwe_out,
  output logic [2:0]              func3_out,
  output logic                    mem_reg_out,
  output logic                    reg_wr_out
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [2:0] op_q, op_d;
  logic an_q, an_d, bn_q, bn_d;
  logic out_valid_q, out_valid_d, zero_q, zero_d, mem_reg_q, mem_reg_d, reg_wr_q, reg_wr_d;
  logic [XLEN-1:0] alu_out_q, alu_out_d, rv2_out_q, rv2_out_d, pc_imm_q, pc_imm_d;
  logic [XLEN-1:0] pc4_q, pc4_d, imm_q, imm_d;
  logic [4:0] rd_q, rd_d;
  logic [1:0] branch_q, branch_d, reg_in_sel_q, reg_in_sel_d;
  logic [3:0] dwe_q, dwe_d;
  logic [2:0] func3_q, func3_d;
  logic [XLEN-1:0] src1, src2, op1, op2, alu_res, res, a_mag, b_mag;
  logic md_en, md_busy, sa, sb, a_neg, b_neg, ge;
  logic [XLEN:0] msum;
  logic [XLEN-1:0] dif, quo, rem, mres, qres, rres, md_res;
  logic [2*XLEN-1:0] mprod;
  assign md_en = (MD_EN != 0) && md_en_in;
  // forwarding: scan from oldest to youngest so the lowest set index wins
  always_comb begin
    src1 = rv1_in;
    src2 = rv2_in;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_rs1_sel_in[k]) src1 = fwd_data_in[k*XLEN +: XLEN];
      if (fwd_rs2_sel_in[k]) src2 = fwd_data_in[k*XLEN +: XLEN];
    end
  end
  assign op1 = alu_src_in[0] ? pc_in : src1;
  assign op2 = alu_src_in[1] ? imm_in : src2;
  // single-cycle ALU
  always_comb begin
    alu_res = '0;
    case (alu_op_in)
      4'd0:    alu_res = op1 + op2;
      4'd1:    alu_res = op1 - op2;
      4'd2:    alu_res = op1 & op2;
      4'd3:    alu_res = op1 | op2;
      4'd4:    alu_res = op1 ^ op2;
      4'd5:    alu_res = op1 << op2[SW-1:0];
      4'd6:    alu_res = op1 >> op2[SW-1:0];
      4'd7:    alu_res = $signed(op1) >>> op2[SW-1:0];
      4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      4'd9:    alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
      4'd10:   alu_res = op2;
      default: alu_res = '0;
    endcase
  end
  assign sa = (md_op_in == 3'd1) | (md_op_in == 3'd2) | (md_op_in == 3'd4) | (md_op_in == 3'd6);
  assign sb = (md_op_in == 3'd1) | (md_op_in == 3'd4) | (md_op_in == 3'd6);
  assign a_neg = sa & src1[XLEN-1];
  assign b_neg = sb & src2[XLEN-1];
  assign a_mag = a_neg ? -src1 : src1;
  assign b_mag = b_neg ? -src2 : src2;
  // acc holds {partial product, multiplier} or {remainder, quotient}; both start as {0, |a|}
  assign msum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign ge = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, opb_q};
  assign dif = acc_q[2*XLEN-2:XLEN-1] - opb_q;
  assign mprod = (an_q ^ bn_q) ? -acc_q : acc_q;
  assign mres = (op_q[1:0] == 2'd0) ? mprod[XLEN-1:0] : mprod[2*XLEN-1:XLEN];
  assign quo = acc_q[XLEN-1:0];
  assign rem = acc_q[2*XLEN-1:XLEN];
  assign qres = (opb_q == '0) ? '1 : (an_q ^ bn_q) ? -quo : quo;
  assign rres = an_q ? -rem : rem;
  assign md_res = !op_q[2] ? mres : op_q[1] ? rres : qres;
  assign md_busy = (in_valid & md_en & (state_q == IDLE)) | (state_q == BUSY);
  assign stall_out = hold_in | md_busy | ((state_q == DONE) & hold_in);
  assign res = (state_q == DONE) ? md_res : alu_res;
  // mul/div sequencer: one shift-add or restoring-divide step per BUSY cycle
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opb_d = opb_q;
    op_d = op_q;
    an_d = an_q;
    bn_d = bn_q;
    if (flush_in) state_d = IDLE;
    else if (state_q == IDLE && in_valid && md_en) begin
      state_d = BUSY;
      cnt_d = CW'(XLEN);
      acc_d = {{XLEN{1'b0}}, a_mag};
      opb_d = b_mag;
      op_d = md_op_in;
      an_d = a_neg;
      bn_d = b_neg;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CW'(1);
      acc_d = op_q[2] ? {ge ? dif : acc_q[2*XLEN-2:XLEN-1], acc_q[XLEN-2:0], ge} : {msum, acc_q[XLEN-1:1]};
      state_d = (cnt_q == CW'(1)) ? DONE : BUSY;
    end else if (state_q == DONE && !hold_in) state_d = IDLE;
  end
  // EX/MEM register next value: flush, then hold, then mul/div bubble, then load
  always_comb begin
    out_valid_d = out_valid_q;
    alu_out_d = alu_out_q;
    rv2_out_d = rv2_out_q;
    pc_imm_d = pc_imm_q;
    pc4_d = pc4_q;
    imm_d = imm_q;
    zero_d = zero_q;
    rd_d = rd_q;
    branch_d = branch_q;
    reg_in_sel_d = reg_in_sel_q;
    dwe_d = dwe_q;
    func3_d = func3_q;
    mem_reg_d = mem_reg_q;
    reg_wr_d = reg_wr_q;
    if (flush_in || (!hold_in && md_busy)) begin
      out_valid_d = 1'b0;
      reg_wr_d = 1'b0;
      dwe_d = '0;
      branch_d = '0;
    end else if (!hold_in) begin
      out_valid_d = in_valid;
      reg_wr_d = in_valid & reg_wr_in;
      dwe_d = in_valid ? dwe_in : '0;
      branch_d = in_valid ? branch_in : '0;
      rd_d = rd_in;
      reg_in_sel_d = reg_in_sel_in;
      func3_d = func3_in;
      mem_reg_d = mem_reg_in;
      alu_out_d = res;
      zero_d = (res == '0);
      rv2_out_d = src2;
      pc_imm_d = pc_in + imm_in;
      pc4_d = pc_in + XLEN'(4);
      imm_d = imm_in;
    end
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      opb_q <= '0;
      op_q <= '0;
      an_q <= 1'b0;
      bn_q <= 1'b0;
      out_valid_q <= 1'b0;
      alu_out_q <= '0;
      rv2_out_q <= '0;
      pc_imm_q <= '0;
      pc4_q <= '0;
      imm_q <= '0;
      zero_q <= 1'b0;
      rd_q <= '0;
      branch_q <= '0;
      reg_in_sel_q <= '0;
      dwe_q <= '0;
      func3_q <= '0;
      mem_reg_q <= 1'b0;
      reg_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opb_q <= opb_d;
      op_q <= op_d;
      an_q <= an_d;
      bn_q <= bn_d;
      out_valid_q <= out_valid_d;
      alu_out_q <= alu_out_d;
      rv2_out_q <= rv2_out_d;
      pc_imm_q <= pc_imm_d;
      pc4_q <= pc4_d;
      imm_q <= imm_d;
      zero_q <= zero_d;
      rd_q <= rd_d;
      branch_q <= branch_d;
      reg_in_sel_q <= reg_in_sel_d;
      dwe_q <= dwe_d;
      func3_q <= func3_d;
      mem_reg_q <= mem_reg_d;
      reg_wr_q <= reg_wr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign alu_out = alu_out_q;
  assign rv2_out = rv2_out_q;
  assign pc_imm_out = pc_imm_q;
  assign pc4_out = pc4_q;
  assign imm_out = imm_q;
  assign zero_out = zero_q;
  assign rd_out = rd_q;
  assign branch_out = branch_q;
  assign reg_in_sel_out = reg_in_sel_q;
  assign dwe_out = dwe_q;
  assign func3_out = func3_q;
  assign mem_reg_out = mem_reg_q;
  assign reg_wr_out = reg_wr_q;
endmodule

// File: tb/tb_exec_stage_md.sv
// tb_exec_stage_md: directed self-checking bench for exec_stage_md
module tb_exec_stage_md;
  localparam int XLEN = 32;
  localparam int NF = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid, flush_in, hold_in, md_en_in, mem_reg_in, reg_wr_in;
  logic [1:0] alu_src_in, branch_in, reg_in_sel_in;
  logic [3:0] alu_op_in, dwe_in;
  logic [2:0] md_op_in, func3_in;
  logic [XLEN-1:0] rv1_in, rv2_in, imm_in, pc_in;
  logic [4:0] rd_in;
  logic [NF-1:0] fwd_rs1_sel_in, fwd_rs2_sel_in;
  logic [NF*XLEN-1:0] fwd_data_in;
  logic stall_out, out_valid, zero_out, mem_reg_out, reg_wr_out;
  logic [XLEN-1:0] alu_out, rv2_out, pc_imm_out, pc4_out, imm_out;
  logic [4:0] rd_out;
  logic [1:0] branch_out, reg_in_sel_out;
  logic [3:0] dwe_out;
  logic [2:0] func3_out;
  int errs = 0, checks = 0;
  exec_stage_md #(.XLEN(XLEN), .NUM_FWD(NF), .MD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush_in(flush_in), .hold_in(hold_in),
    .alu_src_in(alu_src_in), .alu_op_in(alu_op_in), .md_en_in(md_en_in), .md_op_in(md_op_in),
    .branch_in(branch_in), .reg_in_sel_in(reg_in_sel_in), .dwe_in(dwe_in), .func3_in(func3_in),
    .mem_reg_in(mem_reg_in), .reg_wr_in(reg_wr_in), .rv1_in(rv1_in), .rv2_in(rv2_in),
    .imm_in(imm_in), .pc_in(pc_in), .rd_in(rd_in), .fwd_rs1_sel_in(fwd_rs1_sel_in),
    .fwd_rs2_sel_in(fwd_rs2_sel_in), .fwd_data_in(fwd_data_in), .stall_out(stall_out),
    .out_valid(out_valid), .alu_out(alu_out), .rv2_out(rv2_out), .pc_imm_out(pc_imm_out),
    .pc4_out(pc4_out), .imm_out(imm_out), .zero_out(zero_out), .rd_out(rd_out),
    .branch_out(branch_out), .reg_in_sel_out(reg_in_sel_out), .dwe_out(dwe_out),
    .func3_out(func3_out), .mem_reg_out(mem_reg_out), .reg_wr_out(reg_wr_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    in_valid = 0; flush_in = 0; hold_in = 0; alu_src_in = 0; alu_op_in = 0; md_en_in = 0;
    md_op_in = 0; branch_in = 0; reg_in_sel_in = 0; dwe_in = 0; func3_in = 0; mem_reg_in = 0;
    reg_wr_in = 0; rv1_in = 0; rv2_in = 0; imm_in = 0; pc_in = 0; rd_in = 0;
    fwd_rs1_sel_in = 0; fwd_rs2_sel_in = 0; fwd_data_in = 0;
  endtask
  task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] a, b, exp);
    in_valid = 1; md_en_in = 0; alu_op_in = op; rv1_in = a; rv2_in = b;
    tick;
    chk(tag, alu_out, exp);
  endtask
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, b, exp);
    int n = 0, bub = 0;
    in_valid = 1; md_en_in = 1; md_op_in = op; rv1_in = a; rv2_in = b;
    #1;
    while (stall_out && n < 100) begin
      n++;
      if (n > 1 && (out_valid || reg_wr_out)) bub++;
      tick;
    end
    chk({tag, " stall"}, 32'(n), 33);
    chk({tag, " bubble"}, 32'(bub), 0);
    tick;
    chk({tag, " res"}, alu_out, exp);
    chk({tag, " vld"}, 32'(out_valid), 1);
    in_valid = 0; md_en_in = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    clr;
    in_valid = 1; rv1_in = 5; rd_in = 3; reg_wr_in = 1;
    tick;
    tick;
    chk("rst vld", 32'(out_valid), 0);
    chk("rst alu", alu_out, 0);
    chk("rst rd", 32'(rd_out), 0);
    chk("rst regwr", 32'(reg_wr_out), 0);
    chk("rst pc4", pc4_out, 0);
    rst_n = 1;
    clr;
    in_valid = 1; fwd_rs1_sel_in = 2'b11; fwd_data_in = {32'd9, 32'd5}; rv1_in = 100; rv2_in = 3;
    pc_in = 32'h100; imm_in = 32'h20; rd_in = 5; reg_wr_in = 1; dwe_in = 4'hA;
    tick;
    chk("fwd lowest", alu_out, 8);
    chk("fwd vld", 32'(out_valid), 1);
    chk("fwd rd", 32'(rd_out), 5);
    chk("fwd regwr", 32'(reg_wr_out), 1);
    chk("fwd dwe", 32'(dwe_out), 32'hA);
    chk("pc4", pc4_out, 32'h104);
    chk("pcimm", pc_imm_out, 32'h120);
    chk("imm", imm_out, 32'h20);
    chk("rv2 plain", rv2_out, 3);
    chk("zero clr", 32'(zero_out), 0);
    fwd_rs1_sel_in = 2'b10;
    alu("fwd idx1", 0, 100, 3, 12);
    fwd_rs1_sel_in = 0; fwd_rs2_sel_in = 2'b10;
    alu("fwd rs2 sub", 1, 20, 3, 11);
    chk("rv2 fwd", rv2_out, 9);
    fwd_rs2_sel_in = 0; dwe_in = 0;
    alu_src_in = 2'b11;
    alu("pc+imm", 0, 7, 7, 32'h120);
    alu_src_in = 2'b10; imm_in = 32'h55;
    alu("pass imm", 10, 7, 7, 32'h55);
    alu_src_in = 0;
    alu("sra", 7, 32'h80000000, 4, 32'hF8000000);
    alu("srl", 6, 32'h80000000, 4, 32'h08000000);
    alu("sll mask", 5, 1, 35, 8);
    alu("sltu", 9, 1, 32'hFFFFFFFF, 1);
    alu("slt", 8, 1, 32'hFFFFFFFF, 0);
    chk("slt zero", 32'(zero_out), 1);
    alu("slt neg", 8, 32'hFFFFFFFF, 1, 1);
    alu("and", 2, 32'hFF00, 32'h0FF0, 32'h0F00);
    alu("or", 3, 32'hFF00, 32'h0FF0, 32'hFFF0);
    alu("xor", 4, 32'hFF00, 32'h0FF0, 32'hF0F0);
    alu("op12", 12, 32'h1234, 32'h5678, 0);
    chk("op12 zero", 32'(zero_out), 1);
    in_valid = 0;
    tick;
    chk("invalid vld", 32'(out_valid), 0);
    chk("invalid regwr", 32'(reg_wr_out), 0);
    run_md("mulhu", 3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_md("mul", 0, 6, 7, 42);
    run_md("mulh", 1, 32'h80000000, 32'h80000000, 32'h40000000);
    run_md("mulhsu", 2, 32'h80000000, 32'h80000000, 32'hC0000000);
    run_md("div0", 4, 7, 0, 32'hFFFFFFFF);
    run_md("rem0", 6, 7, 0, 7);
    run_md("divovf", 4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_md("removf", 6, 32'h80000000, 32'hFFFFFFFF, 0);
    run_md("divneg", 4, 32'hFFFFFFF9, 2, 32'hFFFFFFFD);
    run_md("remneg", 6, 32'hFFFFFFF9, 2, 32'hFFFFFFFF);
    run_md("divu", 5, 100, 7, 14);
    run_md("remu", 7, 100, 7, 2);
    in_valid = 1; md_en_in = 1; md_op_in = 5; rv1_in = 100; rv2_in = 7;
    repeat (10) tick;
    flush_in = 1;
    tick;
    chk("flush vld", 32'(out_valid), 0);
    chk("flush regwr", 32'(reg_wr_out), 0);
    flush_in = 0; md_en_in = 0; alu_op_in = 0; rv1_in = 1; rv2_in = 2;
    #1;
    chk("flush idle", 32'(stall_out), 0);
    tick;
    chk("post flush add", alu_out, 3);
    chk("post flush vld", 32'(out_valid), 1);
    flush_in = 1; rv1_in = 9;
    tick;
    chk("flush alu vld", 32'(out_valid), 0);
    flush_in = 0;
    alu("reload", 0, 1, 2, 3);
    hold_in = 1; rv1_in = 50;
    #1;
    chk("hold stall", 32'(stall_out), 1);
    tick;
    tick;
    chk("hold alu", alu_out, 3);
    chk("hold vld", 32'(out_valid), 1);
    hold_in = 0;
    tick;
    chk("unhold alu", alu_out, 52);
    in_valid = 1; md_en_in = 1; md_op_in = 0; rv1_in = 6; rv2_in = 7;
    repeat (30) tick;
    hold_in = 1;
    begin
      int bad = 0;
      repeat (5) begin
        tick;
        if (out_valid || !stall_out) bad++;
      end
      chk("done hold frozen", 32'(bad), 0);
    end
    hold_in = 0;
    #1;
    chk("done release stall", 32'(stall_out), 0);
    tick;
    chk("done hold res", alu_out, 42);
    chk("done hold vld", 32'(out_valid), 1);
    md_op_in = 5; rv1_in = 100; rv2_in = 7;
    repeat (5) tick;
    rst_n = 0;
    clr;
    #1;
    chk("arst vld", 32'(out_valid), 0);
    chk("arst alu", alu_out, 0);
    chk("arst regwr", 32'(reg_wr_out), 0);
    chk("arst stall", 32'(stall_out), 0);
    tick;
    rst_n = 1;
    alu("post rst add", 0, 2, 2, 4);
    run_md("post rst divu", 5, 100, 7, 14);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/exec_stage_md.md
Name: exec_stage_md

Overview:
- Parametrised successor of the execute stage.
- Adds: XLEN-wide datapath; N-source operand forwarding; registered EX/MEM output; iterative multiply/divide engine (RV32M semantics) with stall handshake; flush and downstream hold.
- Sits between the ID/EX register and the memory stage; drives the EX/MEM pipeline register directly.

Parameters:
- XLEN, 32: datapath width.
- NUM_FWD, 2: number of forwarding sources. Index 0 is the youngest and has highest priority.
- MD_EN, 1: 1 instantiates the mul/div engine; 0 ties md_en low internally.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction present in EX.
- flush_in  in  1  kill the EX instruction and abort any mul/div.
- hold_in  in  1  downstream stall; output register holds.
- alu_src_in  in  2  bit0: op1 = pc; bit1: op2 = imm.
- alu_op_in  in  4  ALU operation.
- md_en_in  in  1  mul/div instruction.
- md_op_in  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- branch_in  in  2, reg_in_sel_in  in  2, dwe_in  in  4, func3_in  in  3, mem_reg_in  in  1, reg_wr_in  in  1: sideband.
- rv1_in, rv2_in, imm_in, pc_in  in  XLEN  operands.
- rd_in  in  5  destination register.
- fwd_rs1_sel_in, fwd_rs2_sel_in  in  NUM_FWD  per-source forward request.
- fwd_data_in  in  NUM_FWD*XLEN  source k occupies bits [k*XLEN +: XLEN].
- stall_out  out  1  EX occupied; upstream must hold ID/EX stable.
- out_valid  out  1  registered instruction valid.
- alu_out, rv2_out, pc_imm_out, pc4_out, imm_out  out  XLEN  registered results.
- zero_out  out  1.
- rd_out, branch_out, reg_in_sel_out, dwe_out, func3_out, mem_reg_out, reg_wr_out: registered sideband.

Behaviour:
- Reset: all outputs 0, FSM IDLE, iteration counter 0. Reset may assert mid-operation and must abort cleanly.
- Forwarding:
  - src_rs1 = fwd_data of the lowest set index in fwd_rs1_sel_in; rv1_in if no bit is set. rs2 likewise.
  - rv2_out carries the forwarded src_rs2.
- ALU, combinational, op1/op2 selected by alu_src_in:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount = op2[log2(XLEN)-1:0].
  - 8 SLT, 9 SLTU.
  - 10 PASS op2.
  - 11-15 produce 0.
  - zero = (result == 0). All arithmetic mod 2^XLEN.
- pc_imm = pc + imm; pc4 = pc + 4, both mod 2^XLEN.
- Mul/div FSM states IDLE, BUSY, DONE:
  - IDLE -> BUSY when in_valid & md_en & !flush_in. Operands src_rs1/src_rs2 are captured; counter = XLEN.
  - BUSY: one iteration per cycle (shift-add multiply on 2*XLEN-bit product; restoring divide). Counter decrements; at 1 -> DONE.
  - DONE: result is presented. Transition DONE -> IDLE on the first edge with !hold_in, when the output register loads.
  - Multiply: MULH/MULHSU/MULHU return product[2XLEN-1:XLEN] with the matching signedness.
  - Divide by zero: DIV/DIVU quotient = all-ones; REM/REMU = dividend.
  - Signed overflow (min / -1): quotient = min, remainder = 0.
  - Operands are sign-corrected before iteration; result is sign-corrected after.
- stall_out = hold_in | (in_valid & md_en & state==IDLE) | state==BUSY | (state==DONE & hold_in).
  - A mul/div accepted at edge 0 writes the output register at edge XLEN+1 (no hold).
  - stall_out is high for XLEN+1 cycles.
- Output register, each edge, in priority order:
  1. flush_in: out_valid, reg_wr_out, dwe_out, branch_out <= 0; FSM -> IDLE. Other fields are don't-care.
  2. hold_in: all outputs hold.
  3. Mul/div occupying EX with state != DONE: bubble. out_valid, reg_wr, dwe, branch <= 0.
  4. Otherwise: out_valid <= in_valid; sideband <= inputs gated by in_valid (reg_wr, dwe, branch forced 0 if !in_valid); alu_out <= md result if state==DONE, else ALU result.
- Flush during BUSY aborts immediately. The next md instruction restarts from IDLE.
- hold_in during BUSY does not stop the iterations. A DONE result waits until hold_in falls.

Test Plan:
- ADD with fwd_rs1_sel=2'b11, fwd_data[0]=5, fwd_data[1]=9, rv2=3 -> next edge alu_out=8, out_valid=1. Lowest index wins.
- SRA op1=0x80000000, op2=4; SLTU 1 vs 0xFFFFFFFF -> alu_out=0xF8000000, then 1. Op 12 -> 0, zero_out=1.
- MULHU 0xFFFFFFFF*0xFFFFFFFF, XLEN=32 -> stall_out high 33 cycles, bubbles meanwhile; alu_out=0xFFFFFFFE at edge 33.
- DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000; REM same -> 0.
- flush_in at cycle 10 of a DIVU -> out_valid=0, reg_wr_out=0, FSM IDLE. Next ADD completes in 1 cycle.
- hold_in held 5 cycles across DONE -> outputs frozen, result appears on the first edge after release. Reset asserted mid-BUSY -> all outputs 0 immediately.
